uart_tx_feeder: RTL and testbench

//   Byte-buffering stage directly upstream of uart_tx.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_tx_feeder.sv | 78 +++++++
 tb/tb_uart_tx_feeder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, FSM state encoding for the feeder,
// and the 9600-baud divider used by uart_tx instances on the 12 MHz board clock.
package uart_pkg;

  localparam int BYTE_W            = 8;
  localparam int CLKS_PER_BIT_9600 = 1250;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head read.
// Callers qualify wr_en/rd_en; this block never checks full or empty itself.
module sync_fifo #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly ADDR_W bits, so wrap modulo DEPTH is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer in front of uart_tx: producers push at clock rate, and one byte
// is handed to uart_tx per frame (tx_dv pulse, then wait for tx_done).
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              overflow,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              tx_dv,
  output logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_done
);

  feeder_state_e     state;
  logic              empty;
  logic              push;
  logic              pop;
  logic [BYTE_W-1:0] head;

  assign full  = (count == (ADDR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  // Must match the IDLE branch below: the head is consumed on the same edge it is latched.
  assign pop   = (state == ST_IDLE) && !empty;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_dv    <= 1'b0;
      tx_byte  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_dv    <= 1'b0;
      // A push against a full FIFO is dropped even when a pop frees a slot this cycle.
      overflow <= wr_en && full;
      busy     <= !empty || (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            tx_byte <= head;
            tx_dv   <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND: state <= ST_WAIT;
        ST_WAIT: begin
          if (tx_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scenario bench for uart_tx_feeder with a behavioural uart_tx sink (16 clk/bit,
// 10-bit frames) and a queue-based expectation of the transmitted byte stream.
module tb_uart_tx_feeder;

  localparam int DEPTH      = 16;
  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int FRAME_CLKS = 16 * 10;

  logic              clk      = 1'b0;
  logic              rst      = 1'b0;
  logic              wr_en    = 1'b0;
  logic [7:0]        wr_data  = 8'h00;
  logic              full;
  logic              overflow;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_done;

  logic tx_done_model = 1'b0;
  logic inj_done      = 1'b0;
  logic stall         = 1'b0;
  int   sink_cnt      = 0;
  int   dv_seen       = 0;
  int   pass_cnt      = 0;
  int   total_cnt     = 0;

  logic [7:0] sent[$];
  logic [7:0] exp_q[$];
  logic [7:0] acc[$];
  logic [7:0] b0;

  assign tx_done = tx_done_model | inj_done;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .overflow (overflow),
    .count    (count),
    .busy     (busy),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .tx_done  (tx_done)
  );

  // Behavioural uart_tx: latches the byte on tx_dv, pulses tx_done one frame later.
  // It has no reset, so a frame in flight always completes; stall freezes it mid-frame.
  always @(posedge clk) begin
    logic done_next;
    done_next = 1'b0;
    if (tx_dv) begin
      sent.push_back(tx_byte);
      dv_seen++;
      sink_cnt = FRAME_CLKS;
    end else if (sink_cnt > 0 && !stall) begin
      sink_cnt--;
      if (sink_cnt == 0) done_next = 1'b1;
    end
    tx_done_model <= done_next;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && count == 0 && sink_cnt == 0 && !tx_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (count !== 0)        $display("FAIL reset_count: got %0d want 0", count);     else pass_cnt++;
    total_cnt++; if (full !== 1'b0)      $display("FAIL reset_full: got %b want 0", full);        else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0)  $display("FAIL reset_overflow: got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", busy);        else pass_cnt++;
    total_cnt++; if (tx_dv !== 1'b0)     $display("FAIL reset_tx_dv: got %b want 0", tx_dv);      else pass_cnt++;
    total_cnt++; if (tx_byte !== 8'h00)  $display("FAIL reset_tx_byte: got %h want 00", tx_byte); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    bit found;
    sent.delete();
    wr_en = 1'b1; wr_data = 8'h48;
    @(negedge clk);                       // cycle 1
    wr_en = 1'b0;
    total_cnt++; if (tx_dv !== 1'b0) $display("FAIL single_dv_c1: got %b want 0", tx_dv); else pass_cnt++;
    total_cnt++; if (count !== 1)    $display("FAIL single_count_c1: got %0d want 1", count); else pass_cnt++;
    @(negedge clk);                       // cycle 2
    total_cnt++; if (tx_dv !== 1'b1)    $display("FAIL single_dv_c2: got %b want 1", tx_dv); else pass_cnt++;
    total_cnt++; if (tx_byte !== 8'h48) $display("FAIL single_byte_c2: got %h want 48", tx_byte); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1)     $display("FAIL single_busy_c2: got %b want 1", busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (tx_dv !== 1'b0)    $display("FAIL single_dv_c3: got %b want 0", tx_dv); else pass_cnt++;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_done) begin found = 1'b1; break; end
    end
    total_cnt++; if (found !== 1'b1) $display("FAIL single_done_timeout: got %b want 1", found); else pass_cnt++;
    @(negedge clk);                       // tx_done + 1
    total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_t1: got %b want 1", busy); else pass_cnt++;
    @(negedge clk);                       // tx_done + 2
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_t2: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (sent.size() !== 1) $display("FAIL single_frames: got %0d want 1", sent.size()); else pass_cnt++;
  endtask

  task automatic test_hello();
    string msg;
    int    peak;
    bit    ovf_seen;
    bit    ok;
    msg = "Hello, world!\r\n";
    sent.delete();
    exp_q.delete();
    peak = 0;
    ovf_seen = 1'b0;
    for (int i = 0; i < msg.len(); i++) begin
      wr_en = 1'b1; wr_data = msg[i];
      exp_q.push_back(msg[i]);
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
      if (overflow) ovf_seen = 1'b1;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
      if (overflow) ovf_seen = 1'b1;
      if (!busy && count == 0 && sink_cnt == 0 && !tx_done) break;
    end
    wait_idle(10, ok);
    total_cnt++; if (ok !== 1'b1)    $display("FAIL hello_drain: got %b want 1", ok); else pass_cnt++;
    total_cnt++; if (peak !== 14)    $display("FAIL hello_peak: got %0d want 14", peak); else pass_cnt++;
    total_cnt++; if (ovf_seen !== 1'b0) $display("FAIL hello_overflow: got %b want 0", ovf_seen); else pass_cnt++;
    total_cnt++; if (sent.size() !== exp_q.size())
      $display("FAIL hello_frames: got %0d want %0d", sent.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      total_cnt++; if (sent[i] !== exp_q[i])
        $display("FAIL hello_byte[%0d]: got %h want %h", i, sent[i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_random_stream();
    bit ok;
    bit ovf_seen;
    logic [7:0] d;
    sent.delete();
    exp_q.delete();
    ovf_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      wr_en = 1'b1; wr_data = d;
      exp_q.push_back(d);
      @(negedge clk);
      wr_en = 1'b0;
      if (overflow) ovf_seen = 1'b1;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        if (overflow) ovf_seen = 1'b1;
      end
    end
    wait_idle(4000, ok);
    total_cnt++; if (ok !== 1'b1)       $display("FAIL rand_drain: got %b want 1", ok); else pass_cnt++;
    total_cnt++; if (ovf_seen !== 1'b0) $display("FAIL rand_overflow: got %b want 0", ovf_seen); else pass_cnt++;
    total_cnt++; if (sent.size() !== exp_q.size())
      $display("FAIL rand_frames: got %0d want %0d", sent.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      total_cnt++; if (sent[i] !== exp_q[i])
        $display("FAIL rand_byte[%0d]: got %h want %h", i, sent[i], exp_q[i]); else pass_cnt++;
    end
  endtask

  // Sink stalled with the FSM parked in WAIT, so nothing leaves the FIFO.
  task automatic test_overflow();
    int ovf_pulses;
    logic [7:0] d;
    stall = 1'b1;
    sent.delete();
    acc.delete();
    b0 = 8'($urandom);
    wr_en = 1'b1; wr_data = b0;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    ovf_pulses = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      d = 8'($urandom);
      wr_en = 1'b1; wr_data = d;
      if (acc.size() < DEPTH) acc.push_back(d);
      @(negedge clk);
      if (overflow) ovf_pulses++;
      if (i == DEPTH - 2) begin
        total_cnt++; if (count !== DEPTH - 1) $display("FAIL ovf_count_15: got %0d want %0d", count, DEPTH - 1); else pass_cnt++;
        total_cnt++; if (full !== 1'b0)       $display("FAIL ovf_full_15: got %b want 0", full); else pass_cnt++;
      end
      if (i == DEPTH - 1) begin
        total_cnt++; if (count !== DEPTH)     $display("FAIL ovf_count_16: got %0d want %0d", count, DEPTH); else pass_cnt++;
        total_cnt++; if (full !== 1'b1)       $display("FAIL ovf_full_16: got %b want 1", full); else pass_cnt++;
      end
    end
    wr_en = 1'b0;
    @(negedge clk);
    if (overflow) ovf_pulses++;
    total_cnt++; if (ovf_pulses !== 2) $display("FAIL ovf_pulses: got %0d want 2", ovf_pulses); else pass_cnt++;
    total_cnt++; if (count !== DEPTH)  $display("FAIL ovf_count_end: got %0d want %0d", count, DEPTH); else pass_cnt++;
    total_cnt++; if (tx_dv !== 1'b0)   $display("FAIL ovf_no_dv: got %b want 0", tx_dv); else pass_cnt++;
  endtask

  // Continues from test_overflow: full FIFO, FSM in WAIT, sink stalled.
  task automatic test_push_pop_full();
    bit ok;
    inj_done = 1'b1;                      // cycle t
    @(negedge clk);                       // cycle t+1: IDLE, full
    inj_done = 1'b0;
    wr_en = 1'b1; wr_data = 8'($urandom);
    @(negedge clk);                       // cycle t+2
    wr_en = 1'b0;
    total_cnt++; if (count !== DEPTH - 1) $display("FAIL pp_count: got %0d want %0d", count, DEPTH - 1); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1)   $display("FAIL pp_overflow: got %b want 1", overflow); else pass_cnt++;
    total_cnt++; if (tx_dv !== 1'b1)      $display("FAIL pp_dv: got %b want 1", tx_dv); else pass_cnt++;
    total_cnt++; if (tx_byte !== acc[0])  $display("FAIL pp_byte: got %h want %h", tx_byte, acc[0]); else pass_cnt++;
    stall = 1'b0;
    wait_idle(4000, ok);
    exp_q.delete();
    exp_q.push_back(b0);
    foreach (acc[i]) exp_q.push_back(acc[i]);
    total_cnt++; if (ok !== 1'b1) $display("FAIL pp_drain: got %b want 1", ok); else pass_cnt++;
    total_cnt++; if (sent.size() !== exp_q.size())
      $display("FAIL pp_frames: got %0d want %0d", sent.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      total_cnt++; if (sent[i] !== exp_q[i])
        $display("FAIL pp_byte[%0d]: got %h want %h", i, sent[i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int dv_before;
    bit found;
    stall = 1'b1;
    sent.delete();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (count !== 5)    $display("FAIL rmid_count_pre: got %0d want 5", count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1)  $display("FAIL rmid_busy_pre: got %b want 1", busy); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (count !== 0)       $display("FAIL rmid_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (tx_dv !== 1'b0)    $display("FAIL rmid_dv: got %b want 0", tx_dv); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)     $display("FAIL rmid_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (tx_byte !== 8'h00) $display("FAIL rmid_byte: got %h want 00", tx_byte); else pass_cnt++;
    dv_before = dv_seen;
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_done) begin found = 1'b1; break; end
    end
    total_cnt++; if (found !== 1'b1) $display("FAIL rmid_late_done: got %b want 1", found); else pass_cnt++;
    repeat (6) @(negedge clk);
    total_cnt++; if (dv_seen !== dv_before) $display("FAIL rmid_no_dv: got %0d want %0d", dv_seen, dv_before); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)         $display("FAIL rmid_busy_end: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (sent.size() !== 1)     $display("FAIL rmid_frames: got %0d want 1", sent.size()); else pass_cnt++;
  endtask

  task automatic test_done_in_idle();
    int dv_before;
    int dv_hits;
    dv_before = dv_seen;
    dv_hits = 0;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx_dv) dv_hits++;
    end
    total_cnt++; if (dv_hits !== 0)         $display("FAIL idle_done_dv: got %0d want 0", dv_hits); else pass_cnt++;
    total_cnt++; if (dv_seen !== dv_before) $display("FAIL idle_done_frames: got %0d want %0d", dv_seen, dv_before); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)         $display("FAIL idle_done_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (count !== 0)           $display("FAIL idle_done_count: got %0d want 0", count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_hello();
    test_random_stream();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_done_in_idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
